// File: rtl/gpi_periph_pkg.sv
// Shared definitions for the general-purpose input port: register map,
// default width and the address decoder used by the read mux and write logic.
package gpi_periph_pkg;

    localparam int GPI_WIDTH = 8;

    localparam logic [9:0] GPI_DATA_ADDR = 10'h054;
    localparam logic [9:0] GPI_EDGE_ADDR = 10'h058;
    localparam logic [9:0] GPI_IEN_ADDR  = 10'h05C;

    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_DATA = 2'd1,
        SEL_EDGE = 2'd2,
        SEL_IEN  = 2'd3
    } reg_sel_t;

    // Map a bus byte address onto one of the three registers (or none).
    function automatic reg_sel_t decode_addr(input logic [9:0] addr);
        reg_sel_t sel;
        case (addr)
            GPI_DATA_ADDR: sel = SEL_DATA;
            GPI_EDGE_ADDR: sel = SEL_EDGE;
            GPI_IEN_ADDR:  sel = SEL_IEN;
            default:       sel = SEL_NONE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/gpi_debounce.sv
// One-bit debouncer for the input port.
// With GPI_DEBOUNCE_EN defined, a change on 'in' is accepted only after it has
// persisted for DB_CYCLES consecutive cycles; otherwise 'stable' simply
// follows 'in' one cycle later. 'rise' flags the cycle whose clock edge will
// take 'stable' from 0 to 1, so the edge latch can set on that same edge.
module gpi_debounce #(
    parameter int DB_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic in,
    output logic stable,
    output logic rise
);

`ifdef GPI_DEBOUNCE_EN
    localparam int CW = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DB_CYCLES - 1);

    logic [CW-1:0] count;

    assign rise = in && !stable && (count == LAST);

    // Count consecutive disagreeing cycles; flip once the run reaches DB_CYCLES.
    always_ff @(posedge clk) begin
        if (reset) begin
            count  <= '0;
            stable <= 1'b0;
        end else if (in == stable) begin
            count <= '0;
        end else if (count == LAST) begin
            count  <= '0;
            stable <= in;
        end else begin
            count <= count + 1'b1;
        end
    end
`else
    // Debounce length is irrelevant in the plain-register build.
    logic unused_db_cfg;
    assign unused_db_cfg = |32'(DB_CYCLES);

    assign rise = in && !stable;

    // Plain register: accept every change on the next edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            stable <= 1'b0;
        end else begin
            stable <= in;
        end
    end
`endif

endmodule

// File: rtl/gpi_periph.sv
// Memory-mapped general-purpose input port.
// Synchronises the external pins, debounces them (GPI_DEBOUNCE_EN selects the
// counting debouncer, otherwise a single register), latches rising edges in a
// write-one-to-clear status register and drives a registered level interrupt.
// Reads have one cycle of latency and no side effects.
module gpi_periph
    import gpi_periph_pkg::*;
#(
    parameter int WIDTH     = GPI_WIDTH,
    parameter int DB_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [9:0]       address,
    input  logic [WIDTH-1:0] data_in,
    input  logic             write,
    input  logic             read,
    input  logic [WIDTH-1:0] pins_in,
    output logic [WIDTH-1:0] data_out,
    output logic             irq
);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] edge_status;
    logic [WIDTH-1:0] irq_en;
    logic [WIDTH-1:0] clear_mask;
    logic [WIDTH-1:0] rd_data;
    reg_sel_t         sel;

    assign sel = decode_addr(address);

    // Two-flop synchroniser per pin, nothing between the flops.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= pins_in;
            sync2 <= sync1;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        gpi_debounce #(
            .DB_CYCLES (DB_CYCLES)
        ) u_debounce (
            .clk    (clk),
            .reset  (reset),
            .in     (sync2[i]),
            .stable (stable[i]),
            .rise   (rise[i])
        );
    end

    // Bits the CPU asks to clear this cycle; a simultaneous rise still wins.
    assign clear_mask = (write && sel == SEL_EDGE) ? data_in : '0;

    // Edge status and interrupt enable registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            edge_status <= '0;
            irq_en      <= '0;
        end else begin
            edge_status <= (edge_status & ~clear_mask) | rise;
            if (write && sel == SEL_IEN) begin
                irq_en <= data_in;
            end
        end
    end

    // Interrupt follows the registered status/enable one cycle later.
    always_ff @(posedge clk) begin
        if (reset) begin
            irq <= 1'b0;
        end else begin
            irq <= |(edge_status & irq_en);
        end
    end

    // Read mux over current (pre-write) register contents.
    always_comb begin
        rd_data = '0;
        case (sel)
            SEL_DATA: rd_data = stable;
            SEL_EDGE: rd_data = edge_status;
            SEL_IEN:  rd_data = irq_en;
            default:  rd_data = '0;
        endcase
    end

    // Registered read data, zero when no load is in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_out <= '0;
        end else begin
            data_out <= read ? rd_data : '0;
        end
    end

endmodule

// File: tb/tb_gpi_periph.sv
// Testbench for gpi_periph with DB_CYCLES=4; build with and without
// GPI_DEBOUNCE_EN. A cycle-level reference model predicts data_out and irq
// every cycle; directed steps add literal expectations for key scenarios.
module tb_gpi_periph;

    localparam int DB = 4;
`ifdef GPI_DEBOUNCE_EN
    localparam int MDB = DB;
`else
    localparam int MDB = 1;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [9:0] address = '0;
    logic [7:0] data_in = '0;
    logic       write = 1'b0;
    logic       read = 1'b0;
    logic [7:0] pins_in = '0;
    logic [7:0] data_out;
    logic       irq;

    gpi_periph #(
        .WIDTH     (8),
        .DB_CYCLES (DB)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .address  (address),
        .data_in  (data_in),
        .write    (write),
        .read     (read),
        .pins_in  (pins_in),
        .data_out (data_out),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state
    logic [7:0] m_sync1  = '0;
    logic [7:0] m_stable = '0;
    logic [7:0] m_edge   = '0;
    logic [7:0] m_ien    = '0;
    logic [7:0] m_dout   = '0;
    logic       m_irq    = 1'b0;
    logic [7:0] hist[$];   // synchronised pin values, newest first

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] want);
        n_assert++;
        assert (obs === want) else begin
            n_fail++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, want);
        end
    endtask

    // A pin bit is accepted once the last MDB synchronised samples all
    // disagree with the currently accepted value.
    task automatic model_step();
        logic [7:0] flip;
        logic [7:0] nstable;
        logic [7:0] clr;
        if (reset) begin
            m_sync1  = '0;
            m_stable = '0;
            m_edge   = '0;
            m_ien    = '0;
            m_dout   = '0;
            m_irq    = 1'b0;
            hist.push_front(8'h00);
        end else begin
            flip = 8'hFF;
            for (int k = 0; k < MDB; k++) flip &= hist[k] ^ m_stable;
            nstable = m_stable ^ flip;
            clr = (write && address == 10'h058) ? data_in : 8'h00;
            m_irq = |(m_edge & m_ien);
            if (read) begin
                case (address)
                    10'h054: m_dout = m_stable;
                    10'h058: m_dout = m_edge;
                    10'h05C: m_dout = m_ien;
                    default: m_dout = 8'h00;
                endcase
            end else begin
                m_dout = 8'h00;
            end
            m_edge = (m_edge & ~clr) | (flip & nstable);
            if (write && address == 10'h05C) m_ien = data_in;
            m_stable = nstable;
            hist.push_front(m_sync1);
            m_sync1 = pins_in;
        end
        while (hist.size() > MDB) void'(hist.pop_back());
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("model_data_out", data_out, m_dout);
        chk("model_irq", {7'b0, irq}, {7'b0, m_irq});
    endtask

    task automatic idle(input int n);
        repeat (n) cycle();
    endtask

    task automatic wr(input logic [9:0] a, input logic [7:0] d);
        address = a;
        data_in = d;
        write = 1'b1;
        cycle();
        write = 1'b0;
    endtask

    task automatic rd(input logic [9:0] a, output logic [7:0] v);
        address = a;
        read = 1'b1;
        cycle();
        read = 1'b0;
        v = data_out;
    endtask

    initial begin
        logic [7:0] v;
        logic [9:0] addrs[6];
        int hold;
        int op;
        addrs = '{10'h054, 10'h058, 10'h05C, 10'h060, 10'h000, 10'h055};
        for (int k = 0; k < MDB; k++) hist.push_back(8'h00);

        // Reset with all pins high
        reset = 1'b1;
        pins_in = 8'hFF;
        idle(2);
        chk("reset_data_out", data_out, 8'h00);
        chk("reset_irq", {7'b0, irq}, 8'h00);
        reset = 1'b0;
        address = 10'h054;
        read = 1'b1;
        idle(8);
        read = 1'b0;
        chk("release_data", data_out, 8'hFF);

        // Return pins low and clear the edges latched by the initial rise
        pins_in = 8'h00;
        idle(MDB + 4);
        wr(10'h058, 8'hFF);
        rd(10'h058, v);
        chk("edge_cleared", v, 8'h00);

`ifdef GPI_DEBOUNCE_EN
        // 3-cycle glitch rejected, 4-cycle pulse accepted
        pins_in = 8'h01;
        idle(3);
        pins_in = 8'h00;
        idle(10);
        rd(10'h054, v);
        chk("glitch_data", v, 8'h00);
        rd(10'h058, v);
        chk("glitch_edge", v, 8'h00);
        pins_in = 8'h01;
        idle(4);
        pins_in = 8'h00;
        idle(2);
        rd(10'h054, v);
        chk("pulse4_data", v, 8'h01);
        idle(10);
        rd(10'h058, v);
        chk("pulse4_edge", v, 8'h01);
        wr(10'h058, 8'h01);
`endif

        // Edge latch and interrupt on pin 0
        wr(10'h05C, 8'h01);
        pins_in = 8'h01;
        idle(MDB + 3);
        chk("irq_set", {7'b0, irq}, 8'h01);
        rd(10'h058, v);
        chk("edge_pin0", v, 8'h01);
        wr(10'h058, 8'h01);
        chk("irq_lag", {7'b0, irq}, 8'h01);
        cycle();
        chk("irq_clear", {7'b0, irq}, 8'h00);
        pins_in = 8'h00;
        idle(MDB + 3);

        // Clear on the same edge as stable[2] rises: set wins
        pins_in = 8'h04;
        idle(MDB + 1);
        wr(10'h058, 8'h04);
        rd(10'h058, v);
        chk("set_beats_clear", v, 8'h04);
        wr(10'h058, 8'h04);
        rd(10'h058, v);
        chk("w1c_bit2", v, 8'h00);
        pins_in = 8'h00;
        idle(MDB + 3);

        // Register map
        wr(10'h054, 8'hAA);
        rd(10'h054, v);
        chk("data_ro", v, 8'h00);
        rd(10'h060, v);
        chk("unmapped_read", v, 8'h00);
        wr(10'h05C, 8'h3C);
        rd(10'h05C, v);
        chk("ien_readback", v, 8'h3C);
        address = 10'h05C;
        data_in = 8'h11;
        read = 1'b1;
        write = 1'b1;
        cycle();
        read = 1'b0;
        write = 1'b0;
        chk("read_pre_write", data_out, 8'h3C);
        rd(10'h05C, v);
        chk("ien_after_rw", v, 8'h11);
        wr(10'h05C, 8'h00);

        // Reset two cycles into qualifying pin 3
        pins_in = 8'h08;
        idle(2);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        address = 10'h054;
        read = 1'b1;
        idle(MDB + 2);
        chk("requalify_hold", data_out, 8'h00);
        cycle();
        read = 1'b0;
        chk("requalify_done", data_out, 8'h08);
        pins_in = 8'h00;
        idle(MDB + 3);
        wr(10'h058, 8'hFF);

        // Randomised traffic against the model
        hold = 0;
        for (int it = 0; it < 400; it++) begin
            if (hold == 0) begin
                pins_in = 8'($urandom);
                hold = $urandom_range(1, 2 * MDB + 2);
            end
            hold--;
            op = $urandom_range(0, 9);
            address = addrs[$urandom_range(0, 5)];
            data_in = 8'($urandom);
            read  = (op <= 2) || (op == 4);
            write = (op == 3) || (op == 4);
            reset = ($urandom_range(0, 63) == 0);
            cycle();
            read = 1'b0;
            write = 1'b0;
            reset = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
